uart_rx_fifo_feeder: RTL and testbench

- UART receiver that deserialises an asynchronous serial line into bytes and pushes them into the downstream byte FIFO through its write_en/data_in/full interface.
- Sits directly upstream of the FIFO and never writes while full is high. Received bytes that cannot be stored are dropped and flagged.
- Reports framing and overrun errors as sticky flags for software or a status register.

---
 rtl/uart_rx_fifo_feeder.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo_feeder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_feeder.sv
// UART receiver feeding a byte FIFO.
// Deserialises an idle-high asynchronous line (1 start, data_width data bits
// LSB-first, 1 stop, no parity) and pushes each good byte through a
// write_en/data_in strobe. The FIFO is never written while full is high.
// Bytes lost to a full FIFO raise a sticky overrun flag. A low stop bit
// raises a sticky frame_err flag. Both flags clear on clr_err.
module uart_rx_fifo_feeder #(
   parameter int data_width   = 8,
   parameter int clks_per_bit = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  full,
   input  logic                  clr_err,
   output logic                  write_en,
   output logic [data_width-1:0] data_in,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  overrun
);

   // Counter just wide enough to hold clks_per_bit-1
   localparam int CNT_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   localparam int IDX_W = (data_width > 1) ? $clog2(data_width) : 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(clks_per_bit / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clks_per_bit - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(data_width - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      RECOVER = 3'd4
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  rx_meta;
   logic                  rx_s;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic [data_width-1:0] shreg;

   logic                  counting;
   logic                  cnt_done;
   logic                  stop_tick;
   logic                  push;
   logic                  ovr_set;
   logic                  fe_set;

   // Two-flop synchroniser; resets to the idle (high) line level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // START times half a bit to land mid start bit; DATA/STOP time whole bits
   assign counting = (state == START) || (state == DATA) || (state == STOP);
   assign cnt_done = (state == START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // A line that is high again at mid start bit was only a glitch
            if (cnt_done) state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (cnt_done && (idx == IDX_LAST)) state_nxt = STOP;
         end
         STOP: begin
            // Leave at mid stop bit so the next start edge is not missed
            if (cnt_done) state_nxt = rx_s ? IDLE : RECOVER;
         end
         RECOVER: begin
            // Hold off until the line goes idle so a break is not read as 0x00s
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output / event decode from the current state
   always_comb begin
      busy      = (state != IDLE);
      stop_tick = (state == STOP) && cnt_done;
      push      = stop_tick && rx_s && !full;
      ovr_set   = stop_tick && rx_s && full;
      fe_set    = stop_tick && !rx_s;
   end

   // Bit-period counter, bit index and LSB-first shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         cnt <= (counting && !cnt_done) ? cnt + 1'b1 : '0;
         if ((state == DATA) && cnt_done) begin
            shreg <= {rx_s, shreg} >> 1;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else if (state == IDLE) begin
            idx <= '0;
         end
      end
   end

   // FIFO push strobe, held output byte and sticky error flags (set beats clear)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_en  <= 1'b0;
         data_in   <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         write_en <= push;
         if (push) data_in <= shreg;
         if (fe_set)       frame_err <= 1'b1;
         else if (clr_err) frame_err <= 1'b0;
         if (ovr_set)      overrun <= 1'b1;
         else if (clr_err) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Directed testbench for uart_rx_fifo_feeder (data_width=8, clks_per_bit=16).
module tb_uart_rx_fifo_feeder;

   localparam int DW  = 8;
   localparam int CPB = 16;

   logic          clk;
   logic          rst;
   logic          rx;
   logic          full;
   logic          clr_err;
   logic          write_en;
   logic [DW-1:0] data_in;
   logic          busy;
   logic          frame_err;
   logic          overrun;

   int errors;
   int checks;

   uart_rx_fifo_feeder #(.data_width(DW), .clks_per_bit(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .full(full),
      .clr_err(clr_err),
      .write_en(write_en),
      .data_in(data_in),
      .busy(busy),
      .frame_err(frame_err),
      .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter and write monitor
   int            cyc;
   int            wr_cnt;
   int            wr_cyc;
   int            wr_while_full;
   logic [DW-1:0] wr_q[$];
   int            tx_start_cyc;

   initial begin
      cyc = 0;
      wr_cnt = 0;
      wr_cyc = 0;
      wr_while_full = 0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (write_en) begin
         wr_cnt <= wr_cnt + 1;
         wr_cyc <= cyc;
         wr_q.push_back(data_in);
         if (full) wr_while_full <= wr_while_full + 1;
      end
   end

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic hold_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; drives one complete frame
   task automatic send_frame(input logic [DW-1:0] b, input logic stop_v);
      tx_start_cyc = cyc;
      hold_bit(1'b0, CPB);
      for (int i = 0; i < DW; i++) hold_bit(b[i], CPB);
      hold_bit(stop_v, CPB);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b1; full = 1'b0; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b want 0", write_en); end
      checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL reset_data_in: got %h want 00", data_in); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      int n0;
      n0 = wr_cnt;
      wr_q.delete();
      send_frame(8'hA5, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (wr_cnt - n0 !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", wr_cnt - n0); end
      checks++;
      if (wr_q.size() < 1 || wr_q[0] !== 8'hA5) begin
         errors++; $display("FAIL single_data: got %h want a5", (wr_q.size() > 0) ? wr_q[0] : 8'hxx);
      end
      // 2 sync cycles + 8 + 9*16 to stop sample + 1 to strobe
      checks++; if (wr_cyc - tx_start_cyc !== 155) begin errors++; $display("FAIL single_latency: got %0d want 155", wr_cyc - tx_start_cyc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
      checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b want 00", {frame_err, overrun}); end
      repeat (20) @(negedge clk);
      checks++; if (data_in !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h want a5", data_in); end
      checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL single_strobe_width: got %b want 0", write_en); end
   endtask

   task automatic test_back_to_back();
      int n0;
      n0 = wr_cnt;
      wr_q.delete();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (wr_cnt - n0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", wr_cnt - n0); end
      checks++;
      if (wr_q.size() != 2 || wr_q[0] !== 8'h00 || wr_q[1] !== 8'hFF) begin
         errors++; $display("FAIL b2b_data: got %0d bytes first %h want 00 then ff",
                            wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'hxx);
      end
      checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL b2b_flags: got %b want 00", {frame_err, overrun}); end
   endtask

   task automatic test_glitch();
      int n0;
      n0 = wr_cnt;
      hold_bit(1'b0, 3);
      hold_bit(1'b1, 10);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
      repeat (CPB * 11) @(negedge clk);
      checks++; if (wr_cnt !== n0) begin errors++; $display("FAIL glitch_write: got %0d writes want 0", wr_cnt - n0); end
      checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL glitch_flags: got %b want 00", {frame_err, overrun}); end
   endtask

   task automatic test_frame_err();
      int n0;
      n0 = wr_cnt;
      send_frame(8'h3C, 1'b0);
      hold_bit(1'b0, 40);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", frame_err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break: got %b want 1", busy); end
      checks++; if (wr_cnt !== n0) begin errors++; $display("FAIL ferr_write: got %0d writes want 0", wr_cnt - n0); end
      hold_bit(1'b1, 5);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_idle: got %b want 0", busy); end
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ferr_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_overrun();
      int n0;
      n0 = wr_cnt;
      wr_q.delete();
      full = 1'b1;
      send_frame(8'h55, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (wr_cnt !== n0) begin errors++; $display("FAIL ovr_write: got %0d writes want 0", wr_cnt - n0); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
      full = 1'b0;
      send_frame(8'h66, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (wr_cnt - n0 != 1 || wr_q.size() != 1 || wr_q[0] !== 8'h66) begin
         errors++; $display("FAIL ovr_next_data: got %0d writes first %h want 1 write 66",
                            wr_cnt - n0, (wr_q.size() > 0) ? wr_q[0] : 8'hxx);
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ovr_frame_err: got %b want 0", frame_err); end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
      checks++; if (wr_while_full !== 0) begin errors++; $display("FAIL write_while_full: got %0d want 0", wr_while_full); end
   endtask

   task automatic test_reset_mid_frame();
      logic [DW-1:0] b;
      int n0;
      b = 8'h81;
      n0 = wr_cnt;
      wr_q.delete();
      hold_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold_bit(b[i], CPB);
      hold_bit(b[4], CPB / 2);
      rst = 1'b1;
      rx = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL rstmid_data_in: got %h want 00", data_in); end
      checks++; if ({write_en, frame_err, overrun} !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl: got %b want 000", {write_en, frame_err, overrun}); end
      @(negedge clk);
      rst = 1'b0;
      repeat (CPB * 10) @(negedge clk);
      checks++; if (wr_cnt !== n0) begin errors++; $display("FAIL rstmid_no_write: got %0d writes want 0", wr_cnt - n0); end
      send_frame(8'h42, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (wr_cnt - n0 != 1 || wr_q.size() != 1 || wr_q[0] !== 8'h42) begin
         errors++; $display("FAIL rstmid_next_data: got %0d writes first %h want 1 write 42",
                            wr_cnt - n0, (wr_q.size() > 0) ? wr_q[0] : 8'hxx);
      end
      checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL rstmid_flags: got %b want 00", {frame_err, overrun}); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      rx = 1'b1;
      full = 1'b0;
      clr_err = 1'b0;
      tx_start_cyc = 0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
